// File: rtl/ram_dump_streamer_if.sv
// ram_dump_streamer_if: groups the dump request, RAM read port and byte stream signals.
interface ram_dump_streamer_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH-1:0] end_addr;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  busy;
  logic                  done;
  modport master (
    input  start, start_addr, end_addr, mem_rd_data, out_ready,
    output mem_rd_en, mem_addr, out_valid, out_data, out_last, busy, done
  );
  modport slave (
    output start, start_addr, end_addr, mem_rd_data, out_ready,
    input  mem_rd_en, mem_addr, out_valid, out_data, out_last, busy, done
  );
endinterface

// File: rtl/ram_dump_streamer.sv
// ram_dump_streamer: reads RAM[start_addr..end_addr] (wrapping) and streams it out over valid/ready.
module ram_dump_streamer #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input logic                clk,
  input logic                reset,
  ram_dump_streamer_if.master bus
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  out_last_q, out_last_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      last_q     <= '0;
      data_q     <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      last_q     <= last_d;
      data_q     <= data_d;
      out_last_q <= out_last_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    last_d     = last_q;
    data_d     = data_q;
    out_last_d = out_last_q;
    case (state_q)
      IDLE: if (bus.start) begin
        cur_d   = bus.start_addr;
        last_d  = bus.end_addr;
        state_d = READ;
      end
      READ: state_d = WAIT;
      WAIT: begin
        data_d     = bus.mem_rd_data;
        out_last_d = cur_q == last_q;
        state_d    = SEND;
      end
      SEND: if (bus.out_ready) begin
        // cur wraps naturally at 2**ADDR_WIDTH, giving the wrap-around range
        cur_d      = out_last_q ? cur_q : ADDR_WIDTH'(cur_q + 1'b1);
        out_last_d = 1'b0;
        state_d    = out_last_q ? DONE : READ;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign bus.mem_rd_en = state_q == READ;
  assign bus.mem_addr  = cur_q;
  assign bus.out_valid = state_q == SEND;
  assign bus.out_data  = data_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = state_q == READ || state_q == WAIT || state_q == SEND;
  assign bus.done      = state_q == DONE;
endmodule

// File: tb/tb_ram_dump_streamer.sv
// tb_ram_dump_streamer: directed dumps checked against a queue-based model of the expected byte stream.
module tb_ram_dump_streamer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  int   done_cnt = 0;
  int   acc_cyc = 0;
  typedef struct {logic [3:0] addr; logic [7:0] data; logic last;} ent_t;
  ent_t       q[$];
  logic [7:0] rx[$];
  int         rises[$];
  logic [7:0] ram[16];
  logic       pv = 1'b0;
  logic       done_exp = 1'b0;
  ram_dump_streamer_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();
  ram_dump_streamer #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_addr];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask
  always @(negedge clk) begin
    if (reset) begin
      pv = 1'b0;
      done_exp = 1'b0;
    end else begin
      if (bus.mem_rd_en) check("rd_addr", {28'd0, bus.mem_addr}, q.size() != 0 ? {28'd0, q[0].addr} : 32'hDEAD);
      check("busy", {31'd0, bus.busy}, {31'd0, q.size() != 0});
      check("done", {31'd0, bus.done}, {31'd0, done_exp});
      if (bus.done) done_cnt++;
      done_exp = 1'b0;
      if (bus.out_valid) begin
        check("out", {23'd0, bus.out_last, bus.out_data}, q.size() != 0 ? {23'd0, q[0].last, q[0].data} : 32'hDEAD);
        if (!pv) rises.push_back(cyc);
        if (bus.out_ready && q.size() != 0) begin
          rx.push_back(bus.out_data);
          done_exp = q[0].last;
          void'(q.pop_front());
        end
      end else check("last_idle", {31'd0, bus.out_last}, 32'd0);
      pv = bus.out_valid;
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic accept(input logic [3:0] s, input logic [3:0] e);
    int n;
    n = int'(4'(e - s)) + 1;
    bus.start = 1'b1;
    bus.start_addr = s;
    bus.end_addr = e;
    tick(1);
    bus.start = 1'b0;
    acc_cyc = cyc;
    rx.delete();
    rises.delete();
    for (int i = 0; i < n; i++) q.push_back('{addr: 4'(s + i), data: ram[4'(s + i)], last: i == n - 1});
  endtask
  task automatic run(input logic [3:0] s, input logic [3:0] e, input bit stall, input bit poke);
    int d0;
    int n;
    logic [7:0] held;
    d0 = done_cnt;
    n = int'(4'(e - s)) + 1;
    bus.out_ready = !stall;
    accept(s, e);
    if (poke) begin
      tick(4);
      bus.start = 1'b1;
      bus.start_addr = 4'h9;
      bus.end_addr = 4'hA;
      tick(1);
      bus.start = 1'b0;
    end
    if (stall) for (int b = 0; b < n; b++) begin
      for (int k = 0; k < 20 && !bus.out_valid; k++) tick(1);
      held = bus.out_data;
      tick(4);
      check("stall_hold", {24'd0, bus.out_data}, {24'd0, held});
      bus.out_ready = 1'b1;
      tick(1);
      bus.out_ready = 1'b0;
    end
    for (int k = 0; k < 300 && q.size() != 0; k++) tick(1);
    check("drain_timeout", q.size(), 0);
    q.delete();
    tick(2);
    check("done_cnt", done_cnt - d0, 1);
    check("rx_len", rx.size(), n);
    bus.out_ready = 1'b1;
  endtask
  task automatic check_rx(input string nm, input logic [7:0] ex[$]);
    for (int i = 0; i < ex.size(); i++) check(nm, i < rx.size() ? {24'd0, rx[i]} : 32'hDEAD, {24'd0, ex[i]});
  endtask
  initial begin
    logic [7:0] ex[$];
    int d0;
    for (int i = 0; i < 16; i++) ram[i] = 8'h10 + 8'(i);
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.end_addr = '0;
    bus.out_ready = 1'b1;
    bus.mem_rd_data = '0;
    tick(2);
    check("rst_outs", {bus.mem_rd_en, bus.mem_addr, bus.out_valid, bus.out_data, bus.out_last, bus.busy, bus.done}, 0);
    reset = 1'b0;
    tick(1);
    run(4'h2, 4'h5, 1'b0, 1'b0);
    ex = '{8'h12, 8'h13, 8'h14, 8'h15};
    check_rx("basic", ex);
    check("first_valid_lat", rises.size() > 0 ? rises[0] - acc_cyc : -1, 2);
    for (int i = 1; i < 4; i++) check("byte_spacing", rises.size() > i ? rises[i] - rises[i-1] : -1, 3);
    run(4'h2, 4'h5, 1'b1, 1'b0);
    check_rx("backpressure", ex);
    run(4'hE, 4'h1, 1'b0, 1'b0);
    ex = '{8'h1E, 8'h1F, 8'h10, 8'h11};
    check_rx("wrap", ex);
    run(4'h7, 4'h7, 1'b0, 1'b0);
    ex = '{8'h17};
    check_rx("single", ex);
    run(4'h0, 4'hF, 1'b0, 1'b0);
    ex.delete();
    for (int i = 0; i < 16; i++) ex.push_back(8'h10 + 8'(i));
    check_rx("full", ex);
    run(4'h2, 4'h5, 1'b0, 1'b1);
    ex = '{8'h12, 8'h13, 8'h14, 8'h15};
    check_rx("ignored_start", ex);
    d0 = done_cnt;
    bus.out_ready = 1'b0;
    accept(4'h2, 4'h5);
    for (int k = 0; k < 20 && !bus.out_valid; k++) tick(1);
    check("pre_rst_valid", {31'd0, bus.out_valid}, 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst", {bus.out_valid, bus.busy, bus.mem_rd_en}, 0);
    q.delete();
    tick(2);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    tick(3);
    check("no_done_on_rst", done_cnt - d0, 0);
    run(4'h3, 4'h3, 1'b0, 1'b0);
    ex = '{8'h13};
    check_rx("after_rst", ex);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
